// File: rtl/ps2_kbd_rx.sv
// Purpose : host-side PS/2 keyboard receiver; 11-bit frames -> key events with E0/F0 folded in.
// Latency : code_valid 1 cycle after the filtered stop-bit edge (2+FILTER+1 cycles after the pin edge).
// Backpr. : none; the PS/2 device is never throttled and code_valid is a single-cycle pulse.
// Ports   : clk_25mhz/reset (sync, active-high); ps2_clk/ps2_data async line inputs;
//           busy (frame in progress), code_valid/code/extended/key_release (key event),
//           err (framing/parity/timeout pulse), shift_held (left or right shift down).
module ps2_kbd_rx #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       busy,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       extended,
  output logic       key_release,
  output logic       err,
  output logic       shift_held
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, data_filt, clk_filt_q;
  logic [FW-1:0] clk_cnt, data_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity_ok;
  logic          ext_flag, rel_flag;
  logic          edge_evt, timeout, frame_ok, frame_err;

  // Edge event: filtered clock seen high last cycle, low now.
  assign edge_evt = clk_filt_q & ~clk_filt;
  assign timeout  = (state != IDLE) && (timer == TW'(TIMEOUT - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_25mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    if (timeout) begin
      // Timeout takes priority over an edge arriving in the same cycle.
      state_nxt = IDLE;
      frame_err = 1'b1;
    end else if (edge_evt) begin
      case (state)
        IDLE: begin
          if (!data_filt) state_nxt = DATA;
          else            frame_err = 1'b1;
        end
        DATA:   if (bitcnt == 3'd7) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (data_filt && parity_ok) frame_ok  = 1'b1;
          else                        frame_err = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      clk_filt    <= 1'b1;
      data_filt   <= 1'b1;
      clk_filt_q  <= 1'b1;
      clk_cnt     <= '0;
      data_cnt    <= '0;
      timer       <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      parity_ok   <= 1'b0;
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      code_valid  <= 1'b0;
      code        <= '0;
      extended    <= 1'b0;
      key_release <= 1'b0;
      err         <= 1'b0;
      shift_held  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_q <= clk_filt;

      // Glitch filter: the filtered level only follows after FILTER
      // consecutive synced samples disagree with it.
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + FW'(1);
      end

      if (data_sync[1] == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == FW'(FILTER - 1)) begin
        data_filt <= data_sync[1];
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + FW'(1);
      end

      if (state == IDLE || edge_evt || timeout) timer <= '0;
      else                                      timer <= timer + TW'(1);

      if (edge_evt && !timeout) begin
        case (state)
          IDLE:   bitcnt    <= '0;
          DATA: begin
            shreg  <= {data_filt, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: parity_ok <= ^{shreg, data_filt};
          default: ;
        endcase
      end

      code_valid <= 1'b0;
      err        <= frame_err;

      // A bad or aborted frame must not leave a prefix armed for the next key.
      if (frame_err) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end

      if (frame_ok) begin
        if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shreg == 8'hF0) begin
          rel_flag <= 1'b1;
        end else begin
          code        <= shreg;
          extended    <= ext_flag;
          key_release <= rel_flag;
          code_valid  <= 1'b1;
          ext_flag    <= 1'b0;
          rel_flag    <= 1'b0;
          if (!ext_flag && (shreg == 8'h12 || shreg == 8'h59))
            shift_held <= ~rel_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 5000;
  localparam int HALF    = 25;   // PS/2 half-period in system clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_r = 1'b1;
  logic       ps2_data_r = 1'b1;
  logic       busy, code_valid, extended, key_release, err, shift_held;
  logic [7:0] code;

  int vecs = 0, miscompares = 0;
  int cyc = 0, last_fall = 0;
  int ev_cnt = 0, err_cnt = 0, overlap = 0, ev_lat = 0, err_lat = 0;
  logic [7:0] ev_code = 8'h00;
  logic ev_ext = 1'b0, ev_rel = 1'b0;
  int e0, r0;

  ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_25mhz  (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk_r),
    .ps2_data   (ps2_data_r),
    .busy       (busy),
    .code_valid (code_valid),
    .code       (code),
    .extended   (extended),
    .key_release(key_release),
    .err        (err),
    .shift_held (shift_held)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      ev_cnt  = ev_cnt + 1;
      ev_code = code;
      ev_ext  = extended;
      ev_rel  = key_release;
      ev_lat  = cyc - last_fall;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      err_lat = cyc - last_fall;
    end
    if (err && code_valid) overlap = overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data_r = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_r = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_r = 1'b1;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  task automatic line_gap();
    @(posedge clk); #1 ps2_data_r = 1'b1;
    repeat (4 * HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
    logic par;
    par = par_good ? ~^b : ^b;
    send_raw({stop, par, b, 1'b0}, 11);
    line_gap();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_busy"},  {31'd0, busy},        32'd0);
    check({tag, "_cv"},    {31'd0, code_valid},  32'd0);
    check({tag, "_code"},  {24'd0, code},        32'd0);
    check({tag, "_ext"},   {31'd0, extended},    32'd0);
    check({tag, "_rel"},   {31'd0, key_release}, 32'd0);
    check({tag, "_err"},   {31'd0, err},         32'd0);
    check({tag, "_shift"}, {31'd0, shift_held},  32'd0);
  endtask

  task automatic check_event(input string tag, input int n_exp, input logic [7:0] c,
                             input logic x, input logic r);
    check({tag, "_count"}, ev_cnt - e0, n_exp);
    check({tag, "_code"},  {24'd0, ev_code}, {24'd0, c});
    check({tag, "_ext"},   {31'd0, ev_ext},  {31'd0, x});
    check({tag, "_rel"},   {31'd0, ev_rel},  {31'd0, r});
  endtask

  initial begin
    repeat (5) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);

    // 1: plain make code
    e0 = ev_cnt; r0 = err_cnt;
    send_byte(8'h21);
    check_event("t1", 1, 8'h21, 1'b0, 1'b0);
    check("t1_err", err_cnt - r0, 0);
    check("t1_latency", ev_lat, 2 + FILTER + 1);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // 2: break prefix folded
    e0 = ev_cnt;
    send_byte(8'hF0);
    check("t2_no_ev_prefix", ev_cnt - e0, 0);
    send_byte(8'h21);
    check_event("t2", 1, 8'h21, 1'b0, 1'b1);

    // 3: extended break, then plain key has prefixes cleared
    e0 = ev_cnt;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_event("t3", 1, 8'h75, 1'b1, 1'b1);
    e0 = ev_cnt;
    send_byte(8'h1C);
    check_event("t3b", 1, 8'h1C, 1'b0, 1'b0);

    // 4: parity error, stop error on F0, then clean key
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h21, 1'b0, 1'b1);
    check("t4_par_err", err_cnt - r0, 1);
    send_frame(8'hF0, 1'b1, 1'b0);
    check("t4_stop_err", err_cnt - r0, 2);
    check("t4_no_ev", ev_cnt - e0, 0);
    send_byte(8'h1C);
    check_event("t4", 1, 8'h1C, 1'b0, 1'b0);

    // 5: truncated frame -> timeout
    e0 = ev_cnt; r0 = err_cnt;
    send_raw({1'b1, 1'b1, 8'h21, 1'b0}, 5);
    @(negedge clk);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    repeat (6000) @(posedge clk);
    @(negedge clk);
    check("t5_err", err_cnt - r0, 1);
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    check("t5_to_window", (err_lat >= TIMEOUT && err_lat <= TIMEOUT + 2 + FILTER + 4) ? 1 : 0, 1);
    line_gap();
    send_byte(8'h21);
    check_event("t5", 1, 8'h21, 1'b0, 1'b0);

    // 6: shift tracking
    e0 = ev_cnt;
    send_byte(8'h12);
    check("t6_shift_make", {31'd0, shift_held}, 32'd1);
    send_byte(8'hE0); send_byte(8'h12);
    check("t6_shift_ext", {31'd0, shift_held}, 32'd1);
    check_event("t6_ext", 2, 8'h12, 1'b1, 1'b0);
    send_byte(8'hF0); send_byte(8'h12);
    check("t6_shift_break", {31'd0, shift_held}, 32'd0);
    check_event("t6_brk", 3, 8'h12, 1'b0, 1'b1);
    send_byte(8'h59);
    check("t6_rshift_make", {31'd0, shift_held}, 32'd1);

    // glitch on ps2_clk between samples
    e0 = ev_cnt; r0 = err_cnt;
    @(posedge clk); #5 ps2_clk_r = 1'b0; #1 ps2_clk_r = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_glitch_err", err_cnt - r0, 0);
    check("t6_glitch_ev", ev_cnt - e0, 0);
    check("t6_glitch_busy", {31'd0, busy}, 32'd0);

    // reset mid-frame
    send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    @(negedge clk);
    check("t6_busy_pre_rst", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 ps2_data_r = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    e0 = ev_cnt;
    send_byte(8'h1C);
    check_event("t6_post_rst", 1, 8'h1C, 1'b0, 1'b0);

    check("err_cv_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
